// File: rtl/tnet_pkg.sv
// Shared definitions for the tNet transmit framer: frame layout, frame types,
// controller states and the frame checksum.
package tnet_pkg;

    localparam logic [3:0] TNET_T_CMD = 4'h1;
    localparam logic [3:0] TNET_T_KA  = 4'h2;

    // Field LSB positions inside the 128-bit frame
    localparam int TNET_SYNC_LSB = 120;
    localparam int TNET_TYPE_LSB = 116;
    localparam int TNET_OP_LSB   = 111;
    localparam int TNET_SEQ_LSB  = 104;
    localparam int TNET_DT1_LSB  = 72;
    localparam int TNET_DT2_LSB  = 40;
    localparam int TNET_DT3_LSB  = 8;
    localparam int TNET_CSUM_LSB = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] dt1;
        logic [31:0] dt2;
        logic [31:0] dt3;
    } tnet_cmd_t;

    localparam int TNET_CMD_W = $bits(tnet_cmd_t);

    typedef enum logic [1:0] {ST_DOWN, ST_IDLE, ST_SEND} tnet_state_e;

    // XOR of the 15 header bytes that precede the checksum byte
    function automatic logic [7:0] tnet_csum(input logic [119:0] hdr);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 15; i++) x ^= hdr[i*8 +: 8];
        return x;
    endfunction

endpackage

// File: rtl/tnet_tx_framer_fifo.sv
// Command FIFO for the framer: extra-bit pointers, registered level and a
// synchronous flush that dominates writes and reads.
module tnet_cmd_fifo
    import tnet_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = TNET_CMD_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   lvl_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q, lvl_q;
    logic [AW:0]   wptr_d, rptr_d, lvl_d;
    logic          wr, rd;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];
    assign lvl_o     = lvl_q;

    assign wr = wr_en_i && !full_o && !flush_i;
    assign rd = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        lvl_d  = lvl_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            lvl_d  = '0;
        end else begin
            if (wr) wptr_d = wptr_q + (AW+1)'(1);
            if (rd) rptr_d = rptr_q + (AW+1)'(1);
            case ({wr, rd})
                2'b10:   lvl_d = lvl_q + (AW+1)'(1);
                2'b01:   lvl_d = lvl_q - (AW+1)'(1);
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/tnet_tx_framer.sv
// tNet transmit framer: buffers tProc commands, wraps each in a 128-bit frame
// for the Aurora TX stream, inserts keepalives when idle, flushes on link loss.
module tnet_tx_framer
    import tnet_pkg::*;
#(
    parameter int         FIFO_AW   = 2,
    parameter int         KA_PERIOD = 1024,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               user_clk_i,
    input  logic               user_rst_i,
    input  logic               channel_up_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [4:0]         cmd_op_i,
    input  logic [31:0]        cmd_dt1_i,
    input  logic [31:0]        cmd_dt2_i,
    input  logic [31:0]        cmd_dt3_i,
    output logic [127:0]       m_axi_tx_tdata_o,
    output logic               m_axi_tx_tvalid_o,
    input  logic               m_axi_tx_tready_i,
    output logic [6:0]         seq_o,
    output logic [FIFO_AW:0]   fifo_lvl_o,
    output logic [15:0]        flush_cnt_o
);

    localparam int             CW      = $clog2(KA_PERIOD);
    localparam logic [CW-1:0]  KA_LAST = CW'(KA_PERIOD - 1);

    tnet_state_e   state_q, state_d;
    logic [127:0]  tdata_q, tdata_d;
    logic [6:0]    seq_q, seq_d;      // seq of last loaded frame
    logic [6:0]    nseq_q, nseq_d;    // seq the next frame will carry
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   flush_cnt_q;

    tnet_cmd_t     wr_cmd, head, ld_cmd;
    logic [3:0]    ld_type;
    logic          load, fifo_pop, fifo_full, fifo_empty;

    function automatic logic [127:0] build(input logic [3:0] t, input tnet_cmd_t c,
                                           input logic [6:0] s);
        logic [127:0] f;
        f = '0;
        f[TNET_SYNC_LSB +: 8] = SYNC_BYTE;
        f[TNET_TYPE_LSB +: 4] = t;
        f[TNET_OP_LSB   +: 5] = c.op;
        f[TNET_SEQ_LSB  +: 7] = s;
        f[TNET_DT1_LSB  +: 32] = c.dt1;
        f[TNET_DT2_LSB  +: 32] = c.dt2;
        f[TNET_DT3_LSB  +: 32] = c.dt3;
        f[TNET_CSUM_LSB +: 8] = tnet_csum(f[127:8]);
        return f;
    endfunction

    assign wr_cmd      = '{op: cmd_op_i, dt1: cmd_dt1_i, dt2: cmd_dt2_i, dt3: cmd_dt3_i};
    assign cmd_ready_o = channel_up_i && !fifo_full;

    tnet_cmd_fifo #(.AW(FIFO_AW), .DW(TNET_CMD_W)) u_fifo (
        .clk_i     (user_clk_i),
        .rst_i     (user_rst_i),
        .flush_i   (!channel_up_i),
        .wr_en_i   (cmd_valid_i && cmd_ready_o),
        .wr_data_i (wr_cmd),
        .rd_en_i   (fifo_pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .lvl_o     (fifo_lvl_o)
    );

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        seq_d    = seq_q;
        nseq_d   = nseq_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        ld_type  = TNET_T_KA;
        ld_cmd   = '0;
        unique case (state_q)
            ST_DOWN: if (channel_up_i) state_d = ST_IDLE;
            ST_IDLE: begin
                // A queued command always beats a keepalive due this cycle
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    ld_type  = TNET_T_CMD;
                    ld_cmd   = head;
                end else if (cnt_q == KA_LAST) begin
                    load = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SEND: if (m_axi_tx_tready_i) state_d = ST_IDLE;
            default: state_d = ST_DOWN;
        endcase
        if (load) begin
            tdata_d = build(ld_type, ld_cmd, nseq_q);
            seq_d   = nseq_q;
            nseq_d  = nseq_q + 7'd1;
            cnt_d   = '0;
            state_d = ST_SEND;
        end
        // Link loss overrides everything, including an unacknowledged frame
        if (!channel_up_i) begin
            state_d  = ST_DOWN;
            fifo_pop = 1'b0;
            tdata_d  = '0;
            seq_d    = '0;
            nseq_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            state_q     <= ST_DOWN;
            tdata_q     <= '0;
            seq_q       <= '0;
            nseq_q      <= '0;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            tdata_q <= tdata_d;
            seq_q   <= seq_d;
            nseq_q  <= nseq_d;
            cnt_q   <= cnt_d;
            if (!channel_up_i && (!fifo_empty || state_q == ST_SEND) && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign m_axi_tx_tvalid_o = (state_q == ST_SEND);
    assign m_axi_tx_tdata_o  = tdata_q;
    assign seq_o             = seq_q;
    assign flush_cnt_o       = flush_cnt_q;

endmodule

// File: tb/tb_tnet_tx_framer.sv
// Bench for tnet_tx_framer: vector table plus directed link/keepalive cases and
// a randomized run scored against a queue-based model of the framing rules.
module tb_tnet_tx_framer;

    localparam int KA = 16;

    logic         clk = 1'b0;
    logic         rst, up, cv, cr, tv, trdy;
    logic [4:0]   op;
    logic [31:0]  d1, d2, d3;
    logic [127:0] td;
    logic [6:0]   seq;
    logic [2:0]   lvl;
    logic [15:0]  fc;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [6:0] exp_seq = 7'd0;

    always #5 clk = ~clk;

    tnet_tx_framer #(.FIFO_AW(2), .KA_PERIOD(KA), .SYNC_BYTE(8'hA5)) dut (
        .user_clk_i        (clk),
        .user_rst_i        (rst),
        .channel_up_i      (up),
        .cmd_valid_i       (cv),
        .cmd_ready_o       (cr),
        .cmd_op_i          (op),
        .cmd_dt1_i         (d1),
        .cmd_dt2_i         (d2),
        .cmd_dt3_i         (d3),
        .m_axi_tx_tdata_o  (td),
        .m_axi_tx_tvalid_o (tv),
        .m_axi_tx_tready_i (trdy),
        .seq_o             (seq),
        .fifo_lvl_o        (lvl),
        .flush_cnt_o       (fc)
    );

    function automatic logic [127:0] mk_frame(input logic [3:0] t, input logic [4:0] o,
                                              input logic [6:0] s, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        logic [119:0] h;
        logic [7:0]   x;
        h = {8'hA5, t, o, s, a, b, c};
        x = 8'h00;
        for (int i = 0; i < 15; i++) x = x ^ h[i*8 +: 8];
        return {h, x};
    endfunction

    function automatic logic [31:0] kd(input int k);
        return 32'(k + 1) * 32'h01010101;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        int n;
        n = 0;
        cv = 1'b1; op = o; d1 = a; d2 = b; d3 = c;
        while (!cr && n < 50) begin tick; n++; end
        chk("push_ready", {127'd0, cr}, 128'd1);
        tick;
        cv = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        while (!tv && n < 200) begin tick; n++; end
        chk("frame_timeout", {127'd0, tv}, 128'd1);
    endtask

    task automatic take_frame(input string nm, input logic [127:0] exp);
        chk(nm, td, exp);
        chk("seq_o", {121'd0, seq}, {121'd0, exp_seq});
        exp_seq = exp_seq + 7'd1;
        trdy = 1'b1;
        tick;
        chk("tvalid_after_hs", {127'd0, tv}, 128'd0);
    endtask

    typedef struct {
        logic [4:0]   op;
        logic [31:0]  a, b, c;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, c;
        int          e;
    } ent_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         vt[4];
        ent_t         q[$];
        int           n, k;
        logic         acc, prev_tv, prev_trdy, saw127, wrapped;
        logic [127:0] f0, prev_td, ef;
        int           frames;

        vt[0] = '{5'h03, 32'h11111111, 32'h22222222, 32'h33333333,
                  128'hA511_8011_1111_1122_2222_2233_3333_3334};
        vt[1] = '{5'h1F, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 128'd0};
        vt[2] = '{5'h00, 32'h01234567, 32'h89ABCDEF, 32'h5A5A5A5A, 128'd0};
        vt[3] = '{5'h10, 32'h80000001, 32'h7FFFFFFE, 32'hC3C3C3C3, 128'd0};
        for (int i = 1; i < 4; i++)
            vt[i].exp = mk_frame(4'h1, vt[i].op, 7'(i), vt[i].a, vt[i].b, vt[i].c);

        // Reset state
        rst = 1'b1; up = 1'b0; cv = 1'b0; op = '0; d1 = '0; d2 = '0; d3 = '0; trdy = 1'b1;
        #12;
        chk("rst_tvalid", {127'd0, tv}, 128'd0);
        chk("rst_tdata", td, 128'd0);
        chk("rst_seq", {121'd0, seq}, 128'd0);
        chk("rst_lvl", {125'd0, lvl}, 128'd0);
        chk("rst_flush", {112'd0, fc}, 128'd0);
        up = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick; tick;

        // Vector table: one command at a time, tready high
        for (int i = 0; i < 4; i++) begin
            push(vt[i].op, vt[i].a, vt[i].b, vt[i].c);
            if (i == 0) begin
                chk("lat_n1_tvalid", {127'd0, tv}, 128'd0);
                chk("lat_n1_lvl", {125'd0, lvl}, 128'd1);
            end
            wait_frame(n);
            if (i == 0) chk("latency", 128'(n), 128'd1);
            take_frame("tbl_frame", vt[i].exp);
        end

        // Back-pressure: frame held 10 cycles while FIFO fills
        trdy = 1'b0;
        push(5'h07, 32'hCAFEF00D, 32'h0BADF00D, 32'h12345678);
        wait_frame(n);
        f0 = mk_frame(4'h1, 5'h07, exp_seq, 32'hCAFEF00D, 32'h0BADF00D, 32'h12345678);
        chk("stall_frame", td, f0);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            cv = 1'b1; op = 5'(8 + k); d1 = kd(k); d2 = ~kd(k); d3 = kd(k) ^ 32'hDEADBEEF;
            acc = cv && cr;
            tick;
            if (acc) k++;
            chk("stall_tvalid", {127'd0, tv}, 128'd1);
            chk("stall_tdata", td, f0);
        end
        cv = 1'b0;
        chk("stall_accepted", 128'(k), 128'd4);
        chk("stall_ready_low", {127'd0, cr}, 128'd0);
        chk("stall_lvl", {125'd0, lvl}, 128'd4);
        take_frame("stall_f0", f0);
        for (int j = 0; j < 4; j++) begin
            wait_frame(n);
            take_frame("stall_drain",
                       mk_frame(4'h1, 5'(8 + j), exp_seq, kd(j), ~kd(j), kd(j) ^ 32'hDEADBEEF));
        end
        chk("stall_lvl_empty", {125'd0, lvl}, 128'd0);

        // Keepalives: KA idle cycles after each handshake
        for (int r = 0; r < 2; r++) begin
            wait_frame(n);
            chk("ka_gap", 128'(n), 128'(KA));
            take_frame("ka_frame", mk_frame(4'h2, 5'd0, exp_seq, 32'd0, 32'd0, 32'd0));
        end

        // Command present in the cycle a keepalive falls due
        repeat (14) tick;
        chk("win_pre_tvalid", {127'd0, tv}, 128'd0);
        cv = 1'b1; op = 5'h1E; d1 = 32'hA0A0A0A0; d2 = 32'h0B0B0B0B; d3 = 32'h00C0FFEE;
        chk("win_ready", {127'd0, cr}, 128'd1);
        tick;
        cv = 1'b0;
        chk("win_t15_tvalid", {127'd0, tv}, 128'd0);
        tick;
        chk("win_t16_tvalid", {127'd0, tv}, 128'd1);
        take_frame("cmd_wins", mk_frame(4'h1, 5'h1E, exp_seq, 32'hA0A0A0A0, 32'h0B0B0B0B, 32'h00C0FFEE));
        wait_frame(n);
        chk("win_ka_gap", 128'(n), 128'(KA));
        take_frame("win_ka", mk_frame(4'h2, 5'd0, exp_seq, 32'd0, 32'd0, 32'd0));

        // Channel down with a frame in SEND and three commands queued
        trdy = 1'b0;
        push(5'h02, 32'h2, 32'h2, 32'h2);
        wait_frame(n);
        push(5'h03, 32'h3, 32'h3, 32'h3);
        push(5'h04, 32'h4, 32'h4, 32'h4);
        push(5'h05, 32'h5, 32'h5, 32'h5);
        chk("down_pre_lvl", {125'd0, lvl}, 128'd3);
        up = 1'b0;
        tick;
        chk("down_tvalid", {127'd0, tv}, 128'd0);
        chk("down_lvl", {125'd0, lvl}, 128'd0);
        chk("down_flush", {112'd0, fc}, 128'd1);
        chk("down_seq", {121'd0, seq}, 128'd0);
        chk("down_ready", {127'd0, cr}, 128'd0);
        repeat (3) tick;
        chk("down_flush_once", {112'd0, fc}, 128'd1);
        up = 1'b1; trdy = 1'b1; exp_seq = 7'd0;
        tick;
        push(5'h09, 32'h99999999, 32'h88888888, 32'h77777777);
        wait_frame(n);
        take_frame("up_seq0", mk_frame(4'h1, 5'h09, 7'd0, 32'h99999999, 32'h88888888, 32'h77777777));

        // Randomized run against the queue model (also wraps seq)
        prev_tv = 1'b0; prev_trdy = 1'b1; prev_td = td;
        saw127 = 1'b0; wrapped = 1'b0; frames = 0;
        for (int t = 0; t < 3000; t++) begin
            if (tv && !prev_tv) begin
                if (q.size() > 0 && q[0].e <= t - 1) begin
                    ef = mk_frame(4'h1, q[0].op, exp_seq, q[0].a, q[0].b, q[0].c);
                    void'(q.pop_front());
                end else begin
                    ef = mk_frame(4'h2, 5'd0, exp_seq, 32'd0, 32'd0, 32'd0);
                end
                chk("rnd_frame", td, ef);
                chk("rnd_seq", {121'd0, seq}, {121'd0, exp_seq});
                if (exp_seq == 7'd127) saw127 = 1'b1;
                else if (exp_seq == 7'd0 && saw127) wrapped = 1'b1;
                exp_seq = exp_seq + 7'd1;
                frames++;
            end
            if (prev_tv && !prev_trdy) begin
                chk("rnd_hold_tvalid", {127'd0, tv}, 128'd1);
                chk("rnd_hold_tdata", td, prev_td);
            end
            if (prev_tv && prev_trdy) chk("rnd_drop_tvalid", {127'd0, tv}, 128'd0);
            chk("rnd_lvl", {125'd0, lvl}, 128'(q.size()));
            chk("rnd_ready", {127'd0, cr}, {127'd0, q.size() < 4});
            prev_tv = tv; prev_td = td;
            cv   = ($urandom_range(0, 7) < ((t < 1500) ? 1 : 4));
            op   = 5'($urandom);
            d1   = $urandom; d2 = $urandom; d3 = $urandom;
            trdy = 1'($urandom_range(0, 1));
            prev_trdy = trdy;
            if (cv && cr) q.push_back('{op, d1, d2, d3, t + 1});
            tick;
        end
        cv = 1'b0;
        chk("rnd_frames_min", {127'd0, frames >= 130}, 128'd1);
        chk("rnd_seq_wrapped", {127'd0, wrapped}, 128'd1);

        // Asynchronous reset while a frame is pending
        trdy = 1'b0;
        wait_frame(n);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", {127'd0, tv}, 128'd0);
        chk("arst_tdata", td, 128'd0);
        chk("arst_seq", {121'd0, seq}, 128'd0);
        chk("arst_lvl", {125'd0, lvl}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
